// File: rtl/phy_mgmt_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// phy_mgmt_seq : PHY reset bring-up, Clause 22 config write, periodic BMSR poll
// Revision     : 1.0
// ============================================================================
module phy_mgmt_seq #(
  parameter int unsigned RST_CYCLES  = 1_250_000,
  parameter int unsigned WAIT_CYCLES = 6_250_000,
  parameter int unsigned POLL_CYCLES = 12_500_000,
  parameter int unsigned MDC_DIV     = 25,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  INIT_REG    = 5'd0,
  parameter logic [15:0] INIT_DATA   = 16'h1140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic        phy_rst_n,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        init_done,
  output logic        link_up,
  output logic        phy_absent,
  output logic [15:0] bmsr
);

  localparam int               DIV_W    = $clog2(MDC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);
  localparam logic [63:0] WR_FRAME = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, INIT_REG, 2'b10, INIT_DATA};
  localparam logic [63:0] RD_FRAME = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1, 2'b11, 16'hFFFF};

  typedef enum logic [2:0] {
    ST_RST_ASSERT = 3'd0,
    ST_RST_WAIT   = 3'd1,
    ST_INIT_WR    = 3'd2,
    ST_POLL_WAIT  = 3'd3,
    ST_POLL_RD    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic             skip_q, skip_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [63:0]      shift_q, shift_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             phy_rst_n_q, phy_rst_n_d;
  logic             mdc_q, mdc_d;
  logic             mdio_o_q, mdio_o_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic             init_done_q, init_done_d;
  logic             link_up_q, link_up_d;
  logic             phy_absent_q, phy_absent_d;
  logic [15:0]      bmsr_q, bmsr_d;

  logic             start_frame;
  logic [63:0]      start_load;
  logic             is_rd;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    skip_d       = skip_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rd_data_d    = rd_data_q;
    sync1_d      = mdio_i;
    sync2_d      = sync1_q;
    phy_rst_n_d  = phy_rst_n_q;
    mdc_d        = mdc_q;
    mdio_o_d     = mdio_o_q;
    mdio_oe_d    = mdio_oe_q;
    init_done_d  = init_done_q;
    link_up_d    = link_up_q;
    phy_absent_d = phy_absent_q;
    bmsr_d       = bmsr_q;
    start_frame  = 1'b0;
    start_load   = RD_FRAME;
    is_rd        = (state_q == ST_POLL_RD);

    if (restart) begin
      state_d      = ST_RST_ASSERT;
      timer_d      = 32'd0;
      skip_d       = 1'b0;
      div_d        = '0;
      bit_d        = 6'd0;
      phy_rst_n_d  = 1'b0;
      mdc_d        = 1'b0;
      mdio_o_d     = 1'b1;
      mdio_oe_d    = 1'b0;
      init_done_d  = 1'b0;
      link_up_d    = 1'b0;
      phy_absent_d = 1'b0;
      bmsr_d       = 16'h0000;
    end else begin
      unique case (state_q)
        ST_RST_ASSERT: begin
          if (timer_q == RST_CYCLES - 1) begin
            state_d     = ST_RST_WAIT;
            timer_d     = 32'd0;
            phy_rst_n_d = 1'b1;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        ST_RST_WAIT: begin
          if (timer_q == WAIT_CYCLES - 1) begin
            state_d     = ST_INIT_WR;
            start_frame = 1'b1;
            start_load  = WR_FRAME;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        ST_POLL_WAIT: begin
          // skip_q makes the first poll after the config write immediate
          if (skip_q || (timer_q == POLL_CYCLES - 1)) begin
            state_d     = ST_POLL_RD;
            skip_d      = 1'b0;
            start_frame = 1'b1;
            start_load  = RD_FRAME;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        ST_INIT_WR, ST_POLL_RD: begin
          if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
          end else begin
            div_d = '0;
            if (!mdc_q) begin
              mdc_d = 1'b1;
              if (is_rd && (bit_q >= 6'd48))
                rd_data_d = {rd_data_q[14:0], sync2_q};
            end else begin
              mdc_d = 1'b0;
              if (bit_q == 6'd63) begin
                state_d   = ST_POLL_WAIT;
                timer_d   = 32'd0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
                if (is_rd) begin
                  bmsr_d       = rd_data_q;
                  phy_absent_d = &rd_data_q;
                  link_up_d    = rd_data_q[2] & ~(&rd_data_q);
                end else begin
                  init_done_d = 1'b1;
                  skip_d      = 1'b1;
                end
              end else begin
                bit_d     = bit_q + 6'd1;
                shift_d   = {shift_q[62:0], 1'b1};
                mdio_o_d  = shift_q[62];
                // reads release the bus from the turnaround onward
                mdio_oe_d = !is_rd || (bit_q < 6'd45);
              end
            end
          end
        end
        default: state_d = ST_RST_ASSERT;
      endcase

      if (start_frame) begin
        timer_d   = 32'd0;
        div_d     = '0;
        bit_d     = 6'd0;
        mdc_d     = 1'b0;
        shift_d   = start_load;
        mdio_o_d  = start_load[63];
        mdio_oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RST_ASSERT;
      timer_q      <= 32'd0;
      skip_q       <= 1'b0;
      div_q        <= '0;
      bit_q        <= 6'd0;
      shift_q      <= '1;
      rd_data_q    <= 16'h0000;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      phy_rst_n_q  <= 1'b0;
      mdc_q        <= 1'b0;
      mdio_o_q     <= 1'b1;
      mdio_oe_q    <= 1'b0;
      init_done_q  <= 1'b0;
      link_up_q    <= 1'b0;
      phy_absent_q <= 1'b0;
      bmsr_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      skip_q       <= skip_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rd_data_q    <= rd_data_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      phy_rst_n_q  <= phy_rst_n_d;
      mdc_q        <= mdc_d;
      mdio_o_q     <= mdio_o_d;
      mdio_oe_q    <= mdio_oe_d;
      init_done_q  <= init_done_d;
      link_up_q    <= link_up_d;
      phy_absent_q <= phy_absent_d;
      bmsr_q       <= bmsr_d;
    end
  end

  assign phy_rst_n  = phy_rst_n_q;
  assign mdc        = mdc_q;
  assign mdio_o     = mdio_o_q;
  assign mdio_oe    = mdio_oe_q;
  assign init_done  = init_done_q;
  assign link_up    = link_up_q;
  assign phy_absent = phy_absent_q;
  assign bmsr       = bmsr_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_mgmt_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_phy_mgmt_seq : schedule-based reference model, MDIO PHY model, random BMSR
// Revision        : 1.0
// ============================================================================
module tb_phy_mgmt_seq;

  localparam int RSTC   = 16;
  localparam int WAITC  = 32;
  localparam int POLLC  = 200;
  localparam int DIV    = 4;
  localparam int FLEN   = 128 * DIV;
  localparam int S0     = RSTC + WAITC;
  localparam int E0     = S0 + FLEN;
  localparam int S1     = E0 + 1;
  localparam int PERIOD = FLEN + POLLC;
  localparam logic [63:0] WR_EXP = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
  localparam logic [63:0] RD_HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1, 18'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        mdio_i = 1'b1;
  logic        phy_rst_n, mdc, mdio_o, mdio_oe, init_done, link_up, phy_absent;
  logic [15:0] bmsr;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [15:0] rd_val [0:15];
  int          slave_cnt = 0;
  int          slave_rd_n = 0;
  logic        slave_rd = 1'b0;
  logic [63:0] slave_sh = '0;
  logic [63:0] frames [$];

  phy_mgmt_seq #(
    .RST_CYCLES (RSTC),
    .WAIT_CYCLES(WAITC),
    .POLL_CYCLES(POLLC),
    .MDC_DIV    (DIV),
    .PHY_ADDR   (5'd1),
    .INIT_REG   (5'd0),
    .INIT_DATA  (16'h1140)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .phy_rst_n (phy_rst_n),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .init_done (init_done),
    .link_up   (link_up),
    .phy_absent(phy_absent),
    .bmsr      (bmsr)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h required=%h", name, t, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (t < target && n < 20000) begin
      step();
      n++;
    end
    if (t != target) begin
      checks++;
      errors++;
      $display("FAIL wait_t t=%0d required=%0d", t, target);
    end
  endtask

  task automatic count_rstn(output int k);
    k = 0;
    while (!phy_rst_n && k < 5000) begin
      step();
      k++;
    end
  endtask

  task automatic count_oe_while(input logic level, output int k);
    k = 0;
    while (mdio_oe == level && k < 5000) begin
      step();
      k++;
    end
  endtask

  // BMSR values the PHY model returns for reads 1..15 of the current sequence
  task automatic new_epoch_vals(input logic fixed);
    rd_val[0] = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       r = r | 16'h0004;
        1:       r = r & 16'hFFFB;
        2:       r = 16'hFFFF;
        default: r = r;
      endcase
      rd_val[i] = r;
    end
    if (fixed) begin
      rd_val[1] = 16'h796D;
      rd_val[2] = 16'h7969;
      rd_val[3] = 16'hFFFF;
      rd_val[6] = 16'h796D;
    end
    slave_rd_n = 0;
  endtask

  // PHY model: bit counter restarts on each frame, drives read data after mdc falls
  initial forever begin
    @(posedge mdio_oe);
    slave_cnt = 0;
    slave_rd  = 1'b0;
  end

  initial forever begin
    @(posedge mdc);
    slave_sh = {slave_sh[62:0], (mdio_oe ? mdio_o : mdio_i)};
    slave_cnt++;
    if (slave_cnt == 36 && slave_sh[1:0] == 2'b10) begin
      slave_rd = 1'b1;
      slave_rd_n++;
    end
    if (slave_cnt == 64) frames.push_back(slave_sh);
  end

  initial forever begin
    logic [15:0] v;
    @(negedge mdc);
    v = rd_val[slave_rd_n];
    if (slave_rd && slave_cnt >= 48 && slave_cnt <= 63 && v != 16'hFFFF)
      mdio_i = v[63 - slave_cnt];
    else
      mdio_i = 1'b1;
  end

  // Reference schedule: t = clk edges since rst release or restart
  initial begin : compare
    logic        e_rstn, e_mdc, e_oe, e_o, e_ov, e_init, e_abs, e_link, rd, in_fr;
    logic [15:0] e_bmsr;
    logic [63:0] fr;
    int          o, bitn, nd;
    forever begin
      @(posedge clk);
      if (rst || restart) t = 0;
      else t = t + 1;
      @(negedge clk);
      if (rst) begin
        e_rstn = 0; e_mdc = 0; e_oe = 0; e_o = 1; e_ov = 1; e_init = 0; e_bmsr = 16'h0000;
      end else begin
        e_rstn = (t >= RSTC);
        in_fr = 0; rd = 0; o = 0;
        if (t >= S0 && t < E0) begin
          in_fr = 1; o = t - S0;
        end else if (t >= S1) begin
          o = (t - S1) % PERIOD; in_fr = (o < FLEN); rd = 1;
        end
        fr = rd ? RD_HDR : WR_EXP;
        if (in_fr) begin
          bitn = o / (2 * DIV);
          e_mdc = ((o % (2 * DIV)) >= DIV);
          e_oe = !rd || (bitn < 46);
          e_o = fr[63 - bitn];
          e_ov = e_oe;
        end else begin
          e_mdc = 0; e_oe = 0; e_o = 1; e_ov = 1;
        end
        nd = (t < S1 + FLEN) ? 0 : (t - (S1 + FLEN)) / PERIOD + 1;
        if (nd > 15) nd = 15;
        e_bmsr = rd_val[nd];
        e_init = (t >= E0);
      end
      e_abs  = (e_bmsr == 16'hFFFF);
      e_link = e_bmsr[2] && !e_abs;
      chk("phy_rst_n", phy_rst_n, e_rstn);
      chk("mdc", mdc, e_mdc);
      chk("mdio_oe", mdio_oe, e_oe);
      if (e_ov) chk("mdio_o", mdio_o, e_o);
      chk("init_done", init_done, e_init);
      chk("link_up", link_up, e_link);
      chk("phy_absent", phy_absent, e_abs);
      chk("bmsr", bmsr, e_bmsr);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    int nf;
    logic [63:0] f;
    new_epoch_vals(1'b1);
    repeat (5) step();
    rst = 1'b0;

    count_rstn(k);               chk("rst_low", k, 16);
    count_oe_while(1'b0, k);     chk("first_oe", k, 32);
    count_oe_while(1'b1, k);     chk("wr_len", k, 512);
    chk("init_done_lit", init_done, 1);
    chk("wr_frames", frames.size(), 1);
    f = frames[0];
    chk("wr_st", f[31:30], 2'b01);
    chk("wr_op", f[29:28], 2'b01);
    chk("wr_phy", f[27:23], 5'd1);
    chk("wr_reg", f[22:18], 5'd0);
    chk("wr_ta", f[17:16], 2'b10);
    chk("wr_data", f[15:0], 16'h1140);
    count_oe_while(1'b0, k);     chk("wr_rd_gap", k, 1);
    count_oe_while(1'b1, k);     chk("rd_oe_len", k, 368);

    wait_t(1073);
    chk("rd1_bmsr", bmsr, 16'h796D);
    chk("rd1_link", link_up, 1);
    chk("rd1_absent", phy_absent, 0);
    chk("rd_frames", frames.size(), 2);
    f = frames[1];
    chk("rd_st", f[31:30], 2'b01);
    chk("rd_op", f[29:28], 2'b10);
    chk("rd_phy", f[27:23], 5'd1);
    chk("rd_reg", f[22:18], 5'd1);
    chk("rd_data", f[15:0], 16'h796D);
    count_oe_while(1'b0, k);     chk("poll_gap", k, 200);

    wait_t(1785);
    chk("rd2_bmsr", bmsr, 16'h7969);
    chk("rd2_link", link_up, 0);
    wait_t(2497);
    chk("rd3_absent", phy_absent, 1);
    chk("rd3_link", link_up, 0);

    // abort during bit 50 of read 7
    wait_t(5235);
    chk("pre_abort_link", link_up, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    new_epoch_vals(1'b0);
    chk("abort_mdc", mdc, 0);
    chk("abort_oe", mdio_oe, 0);
    chk("abort_mdio_o", mdio_o, 1);
    chk("abort_link", link_up, 0);
    chk("abort_init", init_done, 0);
    count_rstn(k);               chk("rst_low2", k, 16);

    wait_t(2497 + $urandom_range(0, 700));
    restart = 1'b1;
    step();
    restart = 1'b0;
    new_epoch_vals(1'b0);
    wait_t(5);
    restart = 1'b1;
    step();
    restart = 1'b0;
    count_rstn(k);               chk("rst_low3", k, 16);
    count_oe_while(1'b0, k);     chk("first_oe3", k, 32);

    // asynchronous reset in the middle of bit 20 of the config write
    repeat (163) step();
    nf = frames.size();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_phy_rst_n", phy_rst_n, 0);
    chk("arst_mdc", mdc, 0);
    chk("arst_oe", mdio_oe, 0);
    chk("arst_mdio_o", mdio_o, 1);
    chk("arst_init", init_done, 0);
    chk("arst_bmsr", bmsr, 16'h0000);
    repeat (3) step();
    new_epoch_vals(1'b0);
    rst = 1'b0;
    wait_t(1790);
    chk("post_arst_frames", frames.size(), nf + 3);
    f = frames[nf];
    chk("post_arst_wr", f, WR_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
